mandelbrot_pixel_collector: RTL

//   Host-side controller for the mandelbrot engine's run/running/finished/ctr_out interface.

---
 rtl/mandelbrot_pixel_collector.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mandelbrot_pixel_collector.sv
// Host-side pixel collector for the mandelbrot engine: issues run pulses, captures
// 4-bit pixel values, packs pixel pairs into bytes and streams them out of a FWFT FIFO.
module mandelbrot_pixel_collector #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       eng_run,
    input  logic       eng_running,
    input  logic       eng_finished,
    input  logic [3:0] eng_ctr,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic       busy,
    output logic       frame_done,
    output logic       sync_err
);

    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam logic [AW:0]   FULL   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [3:0]    nib_q, nib_d;
    logic          sync_err_q, sync_err_d;
    logic          frame_done_q, frame_done_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [8:0]    mem_d [FIFO_DEPTH];

    logic is_last;
    logic push;
    logic pop;

    assign is_last = (x_q == X_LAST) && (y_q == Y_LAST);
    assign pop     = (count_q != '0) && m_ready;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        nib_d        = nib_q;
        sync_err_d   = sync_err_q;
        frame_done_d = 1'b0;
        eng_run      = 1'b0;
        push         = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_ISSUE;
                    x_d        = '0;
                    y_d        = '0;
                    sync_err_d = 1'b0;
                end
            end
            S_ISSUE: begin
                // Issue only with a free FIFO slot, so a later push can never overflow.
                if (count_q < FULL) begin
                    eng_run = 1'b1;
                    state_d = S_WAIT_START;
                end
            end
            S_WAIT_START: begin
                if (eng_running) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!eng_running) begin
                    if (!x_q[0]) begin
                        nib_d = eng_ctr;
                    end else begin
                        push = 1'b1;
                    end
                    sync_err_d = sync_err_q | (eng_finished != is_last);
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                    if (is_last) begin
                        state_d      = S_DONE;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {is_last, eng_ctr, nib_q};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            nib_q        <= '0;
            sync_err_q   <= 1'b0;
            frame_done_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            mem_q        <= '{default: '0};
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            nib_q        <= nib_d;
            sync_err_q   <= sync_err_d;
            frame_done_q <= frame_done_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            mem_q        <= mem_d;
        end
    end

    assign m_valid          = (count_q != '0);
    assign {m_last, m_data} = mem_q[rd_ptr_q];
    assign busy             = (state_q == S_ISSUE) || (state_q == S_WAIT_START) ||
                              (state_q == S_WAIT_DONE);
    assign frame_done       = frame_done_q;
    assign sync_err         = sync_err_q;

endmodule
